// File: rtl/fp_op_sequencer_if.sv
// fp_op_sequencer_if: operand/result handshake and adder-facing bus of the FP op sequencer
interface fp_op_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] op_A_in;
  logic [31:0] op_B_in;
  logic [2:0]  res_stage_in;
  logic [31:0] res_data_in;
  logic [3:0]  res_status_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_status;
  logic        busy;
  modport master (
    output in_valid, in_a, in_b, res_stage_in, res_data_in, res_status_in, out_ready,
    input  in_ready, op_A_in, op_B_in, out_valid, out_data, out_status, busy
  );
  modport slave (
    input  in_valid, in_a, in_b, res_stage_in, res_data_in, res_status_in, out_ready,
    output in_ready, op_A_in, op_B_in, out_valid, out_data, out_status, busy
  );
endinterface

// File: rtl/fp_op_sequencer.sv
// fp_op_sequencer: feeds operand pairs to the free-running FP adder and returns its result; FP_IEEE_CONV_EN enables IEEE-754 conversion
module fp_op_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic            clock_100kHz,
  input logic            reset,
  fp_op_sequencer_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SKIP, WAIT, HOLD} state_t;
  state_t        state;
  logic [2:0]    stage_q;
  logic [TW-1:0] timer;
  logic          done_p;
  logic          range_err;
  logic [31:0]   conv_a;
  logic [31:0]   conv_b;
  logic [31:0]   res_conv;
  logic [3:0]    stat_conv;
`ifdef FP_IEEE_CONV_EN
  logic [5:0]    rc;
  logic [7:0]    re;
  logic          rs;
  function automatic logic [31:0] to_adder(input logic [31:0] x);
    return {x[31], 6'(x[30:23] - 8'd96), x[22:0], 2'b00};
  endfunction
  function automatic logic bad(input logic [31:0] x);
    return x[30:23] < 8'd97 || x[30:23] > 8'd158;
  endfunction
  assign conv_a    = to_adder(bus.in_a);
  assign conv_b    = to_adder(bus.in_b);
  assign range_err = bad(bus.in_a) || bad(bus.in_b);
  assign rs        = bus.res_data_in[31];
  assign rc        = bus.res_data_in[30:25];
  assign re        = {2'b00, rc} + 8'd96;
  assign res_conv  = (rc == 6'h3F || bus.res_status_in == 4'd1) ? {rs, 8'hFF, 23'd0} :
                     (rc == 6'h00 || bus.res_status_in == 4'd2) ? {rs, 31'd0} :
                     {rs, re, bus.res_data_in[23:1]};
  assign stat_conv = (rc == 6'h3F || bus.res_status_in == 4'd1) ? 4'd1 :
                     (rc == 6'h00 || bus.res_status_in == 4'd2) ? 4'd2 :
                     (bus.res_status_in == 4'd0 && bus.res_data_in[0]) ? 4'd3 : bus.res_status_in;
`else
  assign conv_a    = bus.in_a;
  assign conv_b    = bus.in_b;
  assign range_err = 1'b0;
  assign res_conv  = bus.res_data_in;
  assign stat_conv = bus.res_status_in;
`endif
  assign bus.in_ready = state == IDLE;
  assign bus.busy     = state != IDLE;
  assign done_p       = (bus.res_stage_in === 3'd4) && (stage_q !== 3'd4);
  // previous adder stage code, so completion is seen once per adder run
  always_ff @(posedge clock_100kHz or negedge reset)
    if (!reset) stage_q <= '0;
    else stage_q <= bus.res_stage_in;
  // sequencer: accept, skip the stale run, wait for ours, hold the result until taken
  always_ff @(posedge clock_100kHz or negedge reset)
    if (!reset) begin
      state          <= IDLE;
      timer          <= '0;
      bus.op_A_in    <= '0;
      bus.op_B_in    <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_status <= '0;
    end else begin
      case (state)
        IDLE:
          if (bus.in_valid) begin
            if (range_err) begin
              bus.out_data   <= '0;
              bus.out_status <= 4'd4;
              bus.out_valid  <= 1'b1;
              state          <= HOLD;
            end else begin
              bus.op_A_in <= conv_a;
              bus.op_B_in <= conv_b;
              timer       <= '0;
              state       <= SKIP;
            end
          end
        SKIP, WAIT:
          if (done_p) begin
            timer <= '0;
            if (state == WAIT) begin
              bus.out_data   <= res_conv;
              bus.out_status <= stat_conv;
              bus.out_valid  <= 1'b1;
              state          <= HOLD;
            end else state <= WAIT;
          end else if (timer == T_LAST) begin
            bus.out_data   <= '0;
            bus.out_status <= 4'd8;
            bus.out_valid  <= 1'b1;
            state          <= HOLD;
          end else timer <= timer + 1'b1;
        HOLD:
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fp_op_sequencer.sv
// tb_fp_op_sequencer: directed checks of the FP op sequencer handshake, skip/wait, timeout, hold and reset
module tb_fp_op_sequencer;
  logic clock_100kHz = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
`ifdef FP_IEEE_CONV_EN
  localparam logic [31:0] A1 = 32'h3E000000, R1 = 32'h40000000;
  localparam logic [31:0] A2 = 32'h3F000000, B2 = 32'h3C000000, R2 = 32'h40000000, S2 = 32'd3;
  localparam logic [31:0] A3 = 32'h41000000;
`else
  localparam logic [31:0] A1 = 32'h3F800000, R1 = 32'h41000000;
  localparam logic [31:0] A2 = 32'h3FC00000, B2 = 32'h3F000000, R2 = 32'h41000001, S2 = 32'd0;
  localparam logic [31:0] A3 = 32'h40400000;
`endif
  fp_op_sequencer_if bus();
  fp_op_sequencer #(.TIMEOUT_CYCLES(64)) dut (.clock_100kHz(clock_100kHz), .reset(reset), .bus(bus));
  always #5 clock_100kHz = ~clock_100kHz;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock_100kHz);
    #1;
  endtask
  task automatic pulse();
    bus.res_stage_in = 3'd4;
    tick();
    bus.res_stage_in = 3'd0;
    tick();
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.res_stage_in = '0;
    bus.res_data_in = '0;
    bus.res_status_in = '0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_op_A", bus.op_A_in, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_status", 32'(bus.out_status), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    tick();
    bus.in_a = 32'h3F800000;
    bus.in_b = 32'h3F800000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("t1_op_A", bus.op_A_in, A1);
    chk("t1_op_B", bus.op_B_in, A1);
    chk("t1_in_ready", 32'(bus.in_ready), 32'd0);
    pulse();
    chk("t1_skip_no_valid", 32'(bus.out_valid), 32'd0);
    bus.res_data_in = 32'h41000000;
    bus.res_status_in = 4'd0;
    bus.res_stage_in = 3'd4;
    tick();
    bus.res_stage_in = 3'd0;
    chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_out_data", bus.out_data, R1);
    chk("t1_out_status", 32'(bus.out_status), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t1_release_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_release_ready", 32'(bus.in_ready), 32'd1);
    bus.res_stage_in = 3'd3;
    bus.in_a = 32'h3FC00000;
    bus.in_b = 32'h3F000000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("t2_op_A", bus.op_A_in, A2);
    chk("t2_op_B", bus.op_B_in, B2);
    bus.res_data_in = 32'h12345678;
    bus.res_status_in = 4'd5;
    pulse();
    chk("t2_stale_ignored", 32'(bus.out_valid), 32'd0);
    chk("t2_busy", 32'(bus.busy), 32'd1);
    bus.res_data_in = 32'h41000001;
    bus.res_status_in = 4'd0;
    pulse();
    chk("t2_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t2_out_data", bus.out_data, R2);
    chk("t2_out_status", 32'(bus.out_status), S2);
    bus.res_data_in = 32'hCAFEF00D;
    bus.in_a = 32'h40400000;
    bus.in_b = 32'h40400000;
    bus.in_valid = 1'b1;
    repeat (10) tick();
    chk("hold_valid", 32'(bus.out_valid), 32'd1);
    chk("hold_data", bus.out_data, R2);
    chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    chk("hold_op_A", bus.op_A_in, A2);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("nobypass_valid", 32'(bus.out_valid), 32'd0);
    chk("nobypass_in_ready", 32'(bus.in_ready), 32'd1);
    chk("nobypass_op_A", bus.op_A_in, A2);
    tick();
    bus.in_valid = 1'b0;
    chk("t3_op_A", bus.op_A_in, A3);
    chk("t3_busy", 32'(bus.busy), 32'd1);
    repeat (63) tick();
    chk("to_not_yet", 32'(bus.out_valid), 32'd0);
    tick();
    chk("to_out_valid", 32'(bus.out_valid), 32'd1);
    chk("to_out_data", bus.out_data, 32'd0);
    chk("to_out_status", 32'(bus.out_status), 32'd8);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("to_release", 32'(bus.in_ready), 32'd1);
    bus.in_a = 32'h00000000;
    bus.in_b = 32'h3F800000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
`ifdef FP_IEEE_CONV_EN
    chk("rng_out_valid", 32'(bus.out_valid), 32'd1);
    chk("rng_out_data", bus.out_data, 32'd0);
    chk("rng_out_status", 32'(bus.out_status), 32'd4);
    chk("rng_op_A", bus.op_A_in, A3);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_a = 32'h3F800000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
`else
    chk("raw_op_A_zero", bus.op_A_in, 32'd0);
    chk("raw_no_range_err", 32'(bus.out_valid), 32'd0);
    chk("raw_busy", 32'(bus.busy), 32'd1);
`endif
    pulse();
    chk("wait_busy", 32'(bus.busy), 32'd1);
    bus.res_data_in = 32'h41000000;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_op_A", bus.op_A_in, 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    reset = 1'b1;
    pulse();
    pulse();
    chk("arst_no_result", 32'(bus.out_valid), 32'd0);
    chk("arst_idle", 32'(bus.busy), 32'd0);
    chk("arst_out_data", bus.out_data, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_op_sequencer.md
Name: fp_op_sequencer

Overview:
- Front/back-end stage wrapped around the free-running floating-point adder.
- Accepts operand pairs on a valid/ready handshake and converts IEEE-754 single to the adder's format (sign[31], exp[30:25] bias 31, fraction[24:0]).
- Holds the converted operands stable on op_A_in/op_B_in and watches the adder's qual_lugar stage code to detect completion.
- Captures and converts the result back to IEEE-754 and presents it on an output handshake.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles allowed per wait phase before a timeout result is forced.

Ports:
- clock_100kHz  input  1  system clock
- reset  input  1  asynchronous, active-low
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- in_a  input  32  operand A
- in_b  input  32  operand B
- op_A_in  output  32  operand A to adder (registered)
- op_B_in  output  32  operand B to adder (registered)
- res_stage_in  input  3  adder qual_lugar
- res_data_in  input  32  adder data_out
- res_status_in  input  4  adder status_out
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  32  result
- out_status  output  4  status code: 0 exact, 1 overflow, 2 underflow, 3 inexact, 4 operand range error, 8 timeout
- busy  output  1  state != IDLE

Behaviour:
- Reset is decided: reset reset, asynchronous, active-low; clock clock_100kHz.
- Reset values: op_A_in=0, op_B_in=0, out_valid=0, out_data=0, out_status=0, state=IDLE, stage_q=0, timer=0.
- in_ready is combinational: (state==IDLE).
- done_p = (res_stage_in==3'd4) && (stage_q!=3'd4), where stage_q is res_stage_in registered every cycle. An X on res_stage_in must evaluate done_p false.
- IDLE:
  - on in_valid: register converted operands into op_A_in/op_B_in, clear timer, go to SKIP.
  - If either operand is out of range: leave op_A_in/op_B_in unchanged, out_data=0, out_status=4, go to HOLD.
- SKIP: discard the first done_p, because the adder run in flight may have sampled stale operands. On done_p: clear timer, go to WAIT.
- WAIT: on done_p: out_data=converted res_data_in, out_status=mapped status, out_valid=1, go to HOLD. out_valid is visible the cycle after done_p.
- Timeout in SKIP or WAIT:
  - timer increments each cycle without done_p.
  - on timer==TIMEOUT_CYCLES-1: out_data=0, out_status=8, go to HOLD.
  - timer width is $clog2(TIMEOUT_CYCLES+1).
- HOLD:
  - out_valid=1 with out_data/out_status stable.
  - on out_ready: out_valid=0, go to IDLE.
  - in_valid is ignored.
  - out_valid & out_ready together with in_valid: the new pair is accepted no earlier than the next cycle (no bypass).
- out_ready outside HOLD is ignored.
- op_A_in/op_B_in hold their last value in every state.
- Reset mid-operation: all state aborts and returns to reset values; any pending adder result is never reported.

Optional Feature:
- Macro: FP_IEEE_CONV_EN.
- Defined, input conversion:
  - sign passes through.
  - c = e-96 with 8-bit arithmetic; field = {frac23, 2'b00}.
  - Range error when e<97, e>158, or e==255 (zero, denormal, inf, NaN and exponents outside 1..62).
- Defined, output conversion: res_data_in carries the hidden bit in [24] and fraction in [23:0].
  - c==63 or adder status 1: out={s,8'hFF,23'd0}, status 1.
  - c==0 or adder status 2: out={s,31'd0}, status 2.
  - otherwise: out={s,c+96,res[23:1]}; status = res_status_in, except status 0 becomes 3 when res[0]=1.
- Undefined: in_a/in_b pass raw to op_A_in/op_B_in; res_data_in/res_status_in pass raw to out_data/out_status; status 4 never occurs.

Test Plan:
- CONV_EN, in_a=in_b=0x3F800000 (1.0) -> op_A_in=op_B_in=0x3E000000; adder returns 0x41000000 status 0 -> out_data=0x40000000, out_status=0.
- CONV_EN, in_a=0x3FC00000 (1.5), in_b=0x3F000000 (0.5), applied while the adder is in POS_OPERATION -> first done_p ignored; out_data=0x40000000, out_status=0.
- CONV_EN, in_a=0x00000000 -> out_valid within 2 cycles, out_data=0, out_status=4, op_A_in unchanged.
- res_stage_in tied to 0 after accept -> after 64 cycles in SKIP, out_valid=1, out_data=0, out_status=8.
- out_ready held low 10 cycles in HOLD -> out_valid=1, out_data stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
- reset asserted in WAIT -> immediate out_valid=0, op_A_in=0, state IDLE; later done_p produces no output.
